// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the five-stage RISC-V core. It keeps its own
// copy of the register numbers travelling through Execute, Memory and
// Writeback. From those, and the instruction currently in Decode, it
// produces ALU operand forwarding selects, load-use stalls and branch flushes.
// Two saturating counters record stall and flush cycles for bring-up.
//
// Build option:
//   HAZARD_FWD_EN  defined   -> forwarding from M/W, stall only on load-use
//                  undefined -> pure interlock: forwards tied to 00, stall on
//                               any RAW dependency against E or M
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (outputs forced low while high)
//   Rs1_D        rs1 of the Decode instruction
//   Rs2_D        rs2 of the Decode instruction
//   Rd_D         rd of the Decode instruction
//   RegWrite_D   Decode instruction writes the register file
//   ResultSrc_D  Decode result select (2'b01 = load)
//   PCSrcE       taken branch/jump resolved in Execute
//   Stall_F      hold PC
//   Stall_D      hold IF/ID
//   Flush_D      clear IF/ID
//   Flush_E      clear ID/EX
//   ForwardA_E   SrcA select: 00 regfile, 01 W result, 10 M ALU result
//   ForwardB_E   SrcB select, same encoding
//   StallCount   saturating count of Stall_D cycles
//   FlushCount   saturating count of Flush_D cycles
// ----------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_D,
    input  logic             RegWrite_D,
    input  logic [1:0]       ResultSrc_D,
    input  logic             PCSrcE,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Stage-tracking registers
    logic [4:0]       rs1E_q, rs1E_d;
    logic [4:0]       rs2E_q, rs2E_d;
    logic [4:0]       rdE_q, rdE_d;
    logic             regWriteE_q, regWriteE_d;
    logic             loadE_q, loadE_d;
    logic [4:0]       rdM_q, rdM_d;
    logic             regWriteM_q, regWriteM_d;
    logic [4:0]       rdW_q, rdW_d;
    logic             regWriteW_q, regWriteW_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    // Unforced hazard decisions (before the reset override)
    logic       hazStall;
    logic       stallInt;
    logic       flushEInt;
    logic [1:0] fwdA;
    logic [1:0] fwdB;

`ifdef HAZARD_FWD_EN
    // Forwarding build: M has priority over W, x0 never matches.
    // Only a load in E forces a stall, because its data arrives too late
    // to forward into the dependent instruction's Execute stage.
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (regWriteM_q && (rs1E_q != 5'd0) && (rdM_q == rs1E_q)) begin
            fwdA = 2'b10;
        end else if (regWriteW_q && (rs1E_q != 5'd0) && (rdW_q == rs1E_q)) begin
            fwdA = 2'b01;
        end
        if (regWriteM_q && (rs2E_q != 5'd0) && (rdM_q == rs2E_q)) begin
            fwdB = 2'b10;
        end else if (regWriteW_q && (rs2E_q != 5'd0) && (rdW_q == rs2E_q)) begin
            fwdB = 2'b01;
        end
        hazStall = loadE_q && (rdE_q != 5'd0) &&
                   ((Rs1_D == rdE_q) || (Rs2_D == rdE_q));
    end
`else
    // Interlock build: no bypass paths, so Decode waits until the producer
    // reaches W (the register file writes on the falling edge, making a W
    // result visible to Decode in the same cycle).
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        hazStall = (regWriteE_q && (rdE_q != 5'd0) &&
                    ((Rs1_D == rdE_q) || (Rs2_D == rdE_q))) ||
                   (regWriteM_q && (rdM_q != 5'd0) &&
                    ((Rs1_D == rdM_q) || (Rs2_D == rdM_q)));
    end

    // Tracking state that only the forwarding build consumes
    logic unusedSigs;
    assign unusedSigs = ^{rs1E_q, rs2E_q, loadE_q, rdW_q, regWriteW_q};
`endif

    // A taken branch wins over a stall: the stalled Decode instruction is
    // on the wrong path anyway, so it is flushed rather than held.
    assign stallInt  = hazStall && !PCSrcE;
    assign flushEInt = hazStall || PCSrcE;

    // While reset is high every output is held at zero
    always_comb begin
        Stall_F    = 1'b0;
        Stall_D    = 1'b0;
        Flush_D    = 1'b0;
        Flush_E    = 1'b0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        StallCount = '0;
        FlushCount = '0;
        if (!reset) begin
            Stall_F    = stallInt;
            Stall_D    = stallInt;
            Flush_D    = PCSrcE;
            Flush_E    = flushEInt;
            ForwardA_E = fwdA;
            ForwardB_E = fwdB;
            StallCount = stallCnt_q;
            FlushCount = flushCnt_q;
        end
    end

    // Next state of the tracking pipeline; a flushed E stage becomes a
    // bubble with every field zero so it can never match anything later.
    always_comb begin
        rs1E_d      = Rs1_D;
        rs2E_d      = Rs2_D;
        rdE_d       = Rd_D;
        regWriteE_d = RegWrite_D;
        loadE_d     = (ResultSrc_D == 2'b01);
        if (flushEInt) begin
            rs1E_d      = 5'd0;
            rs2E_d      = 5'd0;
            rdE_d       = 5'd0;
            regWriteE_d = 1'b0;
            loadE_d     = 1'b0;
        end
        rdM_d       = rdE_q;
        regWriteM_d = regWriteE_q;
        rdW_d       = rdM_q;
        regWriteW_d = regWriteM_q;
    end

    // Saturating event counters
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (Stall_D && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
        if (Flush_D && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs1E_q      <= 5'd0;
            rs2E_q      <= 5'd0;
            rdE_q       <= 5'd0;
            regWriteE_q <= 1'b0;
            loadE_q     <= 1'b0;
            rdM_q       <= 5'd0;
            regWriteM_q <= 1'b0;
            rdW_q       <= 5'd0;
            regWriteW_q <= 1'b0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
        end else begin
            rs1E_q      <= rs1E_d;
            rs2E_q      <= rs2E_d;
            rdE_q       <= rdE_d;
            regWriteE_q <= regWriteE_d;
            loadE_q     <= loadE_d;
            rdM_q       <= rdM_d;
            regWriteM_q <= regWriteM_d;
            rdW_q       <= rdW_d;
            regWriteW_q <= regWriteW_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
//
// Drives a cycle-by-cycle table of Decode instructions into two instances of
// hazard_unit (16-bit and 4-bit counters). Each row carries hand-derived
// expected control outputs for both builds; expectations are queued when a
// row is driven and popped when the outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1_D, Rs2_D, Rd_D;
    logic        RegWrite_D;
    logic [1:0]  ResultSrc_D;
    logic        PCSrcE;

    logic        Stall_F, Stall_D, Flush_D, Flush_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [15:0] StallCount, FlushCount;

    logic        nStall_F, nStall_D, nFlush_D, nFlush_E;
    logic [1:0]  nForwardA_E, nForwardB_E;
    logic [3:0]  nStallCount, nFlushCount;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .PCSrcE(PCSrcE),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    hazard_unit #(.CNT_W(4)) dutNarrow (
        .clk(clk), .reset(reset),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
        .RegWrite_D(RegWrite_D), .ResultSrc_D(ResultSrc_D), .PCSrcE(PCSrcE),
        .Stall_F(nStall_F), .Stall_D(nStall_D), .Flush_D(nFlush_D), .Flush_E(nFlush_E),
        .ForwardA_E(nForwardA_E), .ForwardB_E(nForwardB_E),
        .StallCount(nStallCount), .FlushCount(nFlushCount)
    );

`ifdef HAZARD_FWD_EN
    localparam bit FwdMode = 1'b1;
`else
    localparam bit FwdMode = 1'b0;
`endif

    // Expected control word: {stall, flushD, flushE, fwdA[1:0], fwdB[1:0]}
    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rsrc;
        logic       pc;
        logic [6:0] expIl;
        logic [6:0] expFw;
        logic       cntZero;
    } vec_t;

    typedef struct {
        logic [6:0] ctl;
        logic       cntZero;
        int         idx;
    } exp_t;

    localparam int NumVecs = 22;

    vec_t vecs [NumVecs];
    exp_t expQ [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic rw, input logic [1:0] rsrc,
                                input logic pc, input logic [6:0] expIl,
                                input logic [6:0] expFw, input logic cntZero);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rw = rw;
        v.rsrc = rsrc; v.pc = pc; v.expIl = expIl; v.expFw = expFw;
        v.cntZero = cntZero;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        reset       = v.rst;
        Rs1_D       = v.rs1;
        Rs2_D       = v.rs2;
        Rd_D        = v.rd;
        RegWrite_D  = v.rw;
        ResultSrc_D = v.rsrc;
        PCSrcE      = v.pc;
        e.ctl       = FwdMode ? v.expFw : v.expIl;
        e.cntZero   = v.cntZero;
        e.idx       = idx;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard empty actual=0 required=1");
            return;
        end
        e = expQ.pop_front();
        check($sformatf("row%0d Stall_F", e.idx), 32'(Stall_F), 32'(e.ctl[6]));
        check($sformatf("row%0d Stall_D", e.idx), 32'(Stall_D), 32'(e.ctl[6]));
        check($sformatf("row%0d Flush_D", e.idx), 32'(Flush_D), 32'(e.ctl[5]));
        check($sformatf("row%0d Flush_E", e.idx), 32'(Flush_E), 32'(e.ctl[4]));
        check($sformatf("row%0d ForwardA_E", e.idx), 32'(ForwardA_E), 32'(e.ctl[3:2]));
        check($sformatf("row%0d ForwardB_E", e.idx), 32'(ForwardB_E), 32'(e.ctl[1:0]));
        check($sformatf("row%0d narrow ctl", e.idx),
              32'({nStall_D, nFlush_D, nFlush_E, nForwardA_E, nForwardB_E}),
              32'(e.ctl));
        if (e.cntZero) begin
            check($sformatf("row%0d StallCount", e.idx), 32'(StallCount), 32'd0);
            check($sformatf("row%0d FlushCount", e.idx), 32'(FlushCount), 32'd0);
        end
    endtask

    initial begin
        int satCycles;

        //                rst rs1    rs2    rd      rw   rsrc   pc   interlock      forwarding     cnt0
        vecs[0]  = mk(1'b1, 5'd5, 5'd5, 5'd6,  1'b1, 2'd1, 1'b1, 7'b000_00_00, 7'b000_00_00, 1'b1);
        vecs[1]  = mk(1'b0, 5'd0, 5'd3, 5'd5,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b1);
        vecs[2]  = mk(1'b0, 5'd5, 5'd5, 5'd6,  1'b1, 2'd0, 1'b0, 7'b101_00_00, 7'b000_00_00, 1'b0);
        vecs[3]  = mk(1'b0, 5'd5, 5'd5, 5'd6,  1'b1, 2'd0, 1'b0, 7'b101_00_00, 7'b000_10_10, 1'b0);
        vecs[4]  = mk(1'b0, 5'd5, 5'd5, 5'd6,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_01_01, 1'b0);
        vecs[5]  = mk(1'b0, 5'd0, 5'd0, 5'd7,  1'b1, 2'd1, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[6]  = mk(1'b0, 5'd7, 5'd1, 5'd8,  1'b1, 2'd0, 1'b0, 7'b101_00_00, 7'b101_00_00, 1'b0);
        vecs[7]  = mk(1'b0, 5'd7, 5'd1, 5'd8,  1'b1, 2'd0, 1'b0, 7'b101_00_00, 7'b000_00_00, 1'b0);
        vecs[8]  = mk(1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 7'b000_00_00, 7'b000_01_00, 1'b0);
        vecs[9]  = mk(1'b0, 5'd0, 5'd0, 5'd7,  1'b1, 2'd1, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[10] = mk(1'b0, 5'd7, 5'd7, 5'd9,  1'b1, 2'd0, 1'b1, 7'b011_00_00, 7'b011_00_00, 1'b0);
        vecs[11] = mk(1'b0, 5'd0, 5'd1, 5'd0,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[12] = mk(1'b0, 5'd0, 5'd0, 5'd9,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[13] = mk(1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[14] = mk(1'b0, 5'd0, 5'd0, 5'd5,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[15] = mk(1'b0, 5'd0, 5'd0, 5'd5,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[16] = mk(1'b0, 5'd5, 5'd2, 5'd11, 1'b1, 2'd0, 1'b0, 7'b101_00_00, 7'b000_00_00, 1'b0);
        vecs[17] = mk(1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 2'd0, 1'b0, 7'b000_00_00, 7'b000_10_00, 1'b0);
        // Reset pulsed in the middle of a load-use stall
        vecs[18] = mk(1'b0, 5'd0, 5'd0, 5'd7,  1'b1, 2'd1, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b0);
        vecs[19] = mk(1'b0, 5'd7, 5'd1, 5'd8,  1'b1, 2'd0, 1'b0, 7'b101_00_00, 7'b101_00_00, 1'b0);
        vecs[20] = mk(1'b1, 5'd7, 5'd1, 5'd8,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b1);
        vecs[21] = mk(1'b0, 5'd7, 5'd1, 5'd8,  1'b1, 2'd0, 1'b0, 7'b000_00_00, 7'b000_00_00, 1'b1);

        $display("[TB] hazard_unit bench, forwarding build = %0d", FwdMode);

        reset = 1'b1; Rs1_D = '0; Rs2_D = '0; Rd_D = '0;
        RegWrite_D = 1'b0; ResultSrc_D = 2'b00; PCSrcE = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i], i);
            @(negedge clk);
            checkOutput();
        end

        // Edges through row 16 have been counted by now
        check("StallCount after table", 32'(StallCount), FwdMode ? 32'd1 : 32'd5);
        check("FlushCount after table", 32'(FlushCount), 32'd1);
        check("narrow StallCount after table", 32'(nStallCount), FwdMode ? 32'd1 : 32'd5);

        for (int i = 18; i < NumVecs; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i], i);
            @(negedge clk);
            checkOutput();
        end

        // Saturation: a repeating dependency pattern yields exactly 20 stall
        // cycles (2 of every 3 in interlock mode, 1 of every 2 with forwarding)
        satCycles = FwdMode ? 40 : 30;
        @(posedge clk); #1;
        reset = 1'b1; Rs1_D = 5'd3; Rs2_D = 5'd0; Rd_D = 5'd3;
        RegWrite_D = 1'b1; ResultSrc_D = FwdMode ? 2'b01 : 2'b00; PCSrcE = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (satCycles) @(posedge clk);
        @(negedge clk);
        check("StallCount 20 stalls", 32'(StallCount), 32'd20);
        check("narrow StallCount saturated", 32'(nStallCount), 32'd15);
        check("FlushCount no branches", 32'(FlushCount), 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("narrow StallCount holds", 32'(nStallCount), 32'd15);

        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard leftover actual=%0d required=0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
